// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter and mul/div scoreboard.
// Shares the single write port between the in-order writeback path and the
// mul/div unit. A pending mul/div result is forced through after STARVE_LIMIT
// blocked cycles. Also tracks destinations of in-flight mul/div results so
// decode can be stalled on RAW and WAW hazards.
module regfile_wb_arbiter #(
    parameter int ADDR_SIZE     = 5,
    parameter int XLEN          = 64,
    parameter int NUM_REGISTERS = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_valid_i,
    input  logic [ADDR_SIZE-1:0] wb_addr_i,
    input  logic [XLEN-1:0]      wb_data_i,
    input  logic                 md_valid_i,
    output logic                 md_ready_o,
    input  logic [ADDR_SIZE-1:0] md_addr_i,
    input  logic [XLEN-1:0]      md_data_i,
    input  logic                 md_issue_i,
    input  logic [ADDR_SIZE-1:0] md_issue_addr_i,
    input  logic                 dec_rs1_en_i,
    input  logic                 dec_rs2_en_i,
    input  logic [ADDR_SIZE-1:0] dec_rs1_i,
    input  logic [ADDR_SIZE-1:0] dec_rs2_i,
    input  logic                 dec_rd_en_i,
    input  logic [ADDR_SIZE-1:0] dec_rd_i,
    output logic                 write_enable_o,
    output logic [ADDR_SIZE-1:0] write_addr_o,
    output logic [XLEN-1:0]      write_data_o,
    output logic                 dec_stall_o,
    output logic                 stall_pipe_o,
    output logic                 wb_drop_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [NUM_REGISTERS-1:0] busy_q, busy_d;
    logic [3:0]               wait_cnt_q, wait_cnt_d;
    logic                     wb_drop_q, wb_drop_d;

    logic                     md_accept;
    logic                     grant;
    logic [ADDR_SIZE-1:0]     grant_addr;
    logic [XLEN-1:0]          grant_data;
    logic [NUM_REGISTERS-1:0] clear_mask;
    logic [NUM_REGISTERS-1:0] set_mask;
    logic [NUM_REGISTERS-1:0] busy_eff;

    // Mux-style lookup keeps the index within the scoreboard for any width pairing.
    function automatic logic busy_at(input logic [NUM_REGISTERS-1:0] vec,
                                     input logic [ADDR_SIZE-1:0]     a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            if (a == ADDR_SIZE'(i)) hit = vec[i];
        end
        return hit;
    endfunction

    // Zero-cycle arbitration: a starved mul/div result wins over writeback.
    always_comb begin
        stall_pipe_o = md_valid_i & (wait_cnt_q == LIMIT);
        md_ready_o   = ~wb_valid_i | stall_pipe_o;
        md_accept    = md_valid_i & md_ready_o;
        grant        = md_accept | wb_valid_i;
        grant_addr   = md_accept ? md_addr_i : wb_addr_i;
        grant_data   = md_accept ? md_data_i : wb_data_i;

        write_enable_o = grant & (grant_addr != '0);
        write_addr_o   = write_enable_o ? grant_addr : '0;
        write_data_o   = write_enable_o ? grant_data : '0;
    end

    // Scoreboard masks, bypass-adjusted busy view, and hazard detection.
    always_comb begin
        clear_mask = '0;
        set_mask   = '0;
        for (int i = 1; i < NUM_REGISTERS; i++) begin
            clear_mask[i] = md_accept  & (md_addr_i == ADDR_SIZE'(i));
            set_mask[i]   = md_issue_i & (md_issue_addr_i == ADDR_SIZE'(i));
        end
        busy_eff = busy_q & ~clear_mask;

        busy_d    = (busy_q & ~clear_mask) | set_mask;
        busy_d[0] = 1'b0;

        dec_stall_o = (dec_rs1_en_i & busy_at(busy_eff, dec_rs1_i))
                    | (dec_rs2_en_i & busy_at(busy_eff, dec_rs2_i))
                    | (dec_rd_en_i  & busy_at(busy_eff, dec_rd_i))
                    | (md_issue_i   & busy_at(busy_eff, md_issue_addr_i));
    end

    // Starvation counter and sticky lost-writeback flag.
    always_comb begin
        if (~md_valid_i | md_accept) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        wb_drop_d = wb_drop_q | (wb_valid_i & stall_pipe_o);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= '0;
            wait_cnt_q <= 4'd0;
            wb_drop_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            wait_cnt_q <= wait_cnt_d;
            wb_drop_q  <= wb_drop_d;
        end
    end

    assign wb_drop_o = wb_drop_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the integer register file. It shares the file's single write port between two producers: the in-order pipeline writeback (ALU/load, no backpressure) and the long-latency M-extension multiply/divide unit (valid/ready). It tracks destination registers with outstanding mul/div results and raises decode stalls for RAW and WAW hazards. It also guarantees that a pending mul/div result is written back within a bounded number of cycles.

## Interface
- ADDR_SIZE, 5, register address width
- XLEN, 64, data width
- NUM_REGISTERS, 32, scoreboard depth (one busy bit per register)
- STARVE_LIMIT, 4, consecutive blocked cycles before a pipeline bubble is forced (legal range 1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- wb_valid  in  1  pipeline writeback request
- wb_addr  in  ADDR_SIZE  pipeline destination
- wb_data  in  XLEN  pipeline result (signed)
- md_valid  in  1  mul/div result valid
- md_ready  out  1  mul/div result accepted this cycle when md_valid is also high
- md_addr  in  ADDR_SIZE  mul/div destination
- md_data  in  XLEN  mul/div result (signed)
- md_issue  in  1  mul/div instruction dispatched this cycle
- md_issue_addr  in  ADDR_SIZE  its destination
- dec_rs1_en, dec_rs2_en  in  1 each  decode source operands in use
- dec_rs1, dec_rs2  in  ADDR_SIZE each  decode source addresses
- dec_rd_en  in  1  decode instruction writes a register
- dec_rd  in  ADDR_SIZE  decode destination
- write_enable  out  1  register file write enable
- write_addr  out  ADDR_SIZE  register file write address
- write_data  out  XLEN  register file write data
- dec_stall  out  1  decode must hold its instruction
- stall_pipe  out  1  pipeline must present a bubble at writeback this cycle
- wb_drop  out  1  sticky error flag

## Operation
- **State**
  - busy[NUM_REGISTERS-1:0]
  - wait_cnt (4 bits)
  - wb_drop flag
- **Arbitration** (combinational each cycle)
  - stall_pipe = md_valid & (wait_cnt == STARVE_LIMIT).
  - md_ready = ~wb_valid | stall_pipe.
  - Grant mul/div when md_valid & md_ready. Otherwise grant the pipeline when wb_valid. Otherwise grant nothing.
  - Write port carries the granted source's address and data.
  - write_enable = grant & (granted addr != 0). When write_enable is 0, write_addr and write_data are driven to 0.
- **Starvation counter**
  - Increments when md_valid & ~md_ready, saturating at STARVE_LIMIT.
  - Clears to 0 when md_valid is low or on mul/div acceptance.
- **Protocol violation**
  - wb_valid high while stall_pipe is high: the mul/div unit still wins, and the pipeline write is lost.
  - wb_drop sets and stays set until rst.
- **Scoreboard**
  - md_issue with md_issue_addr != 0 sets busy[md_issue_addr] at the next edge.
  - Mul/div acceptance clears busy[md_addr].
  - If a set and a clear hit the same address in the same cycle, the set wins.
  - busy[0] is always 0.
- **Effective busy**: busy_eff = busy & ~clear_mask, where clear_mask is the one-hot of md_addr on this cycle's acceptance. This matches the register file's same-cycle write-to-read bypass.
- **dec_stall** is high when any of the following holds:
  - dec_rs1_en & busy_eff[dec_rs1]
  - dec_rs2_en & busy_eff[dec_rs2]
  - dec_rd_en & busy_eff[dec_rd] (WAW)
  - md_issue & busy_eff[md_issue_addr] (second in-flight write to the same register)
- **Stall contract**: decode does not assert md_issue while dec_stall is high. If it does anyway, busy is still set.

## Timing
- **Reset values** (after a reset edge)
  - busy = 0, wait_cnt = 0, wb_drop = 0.
  - With all inputs low: write_enable = 0, write_addr = 0, write_data = 0, md_ready = 1, dec_stall = 0, stall_pipe = 0.
- **Reset mid-operation**
  - Discards all busy bits and the counter. An in-flight md_valid is treated as a fresh request from the cycle after reset.
  - If rst is high in the same cycle as an acceptance, the write still reaches the port; the scoreboard clear is overridden by reset.
- **Latency**
  - Write port outputs, md_ready, stall_pipe and dec_stall are combinational in the same cycle: zero-cycle arbitration.
  - A busy bit becomes visible to dec_stall one cycle after md_issue.
- **Worst-case mul/div wait**: STARVE_LIMIT+1 cycles from md_valid rising to acceptance under continuous wb_valid.
- **Handshake rule**: md_addr and md_data are held stable while md_valid & ~md_ready.

## Test plan
- **Reset**: assert rst with random inputs -> next cycle busy = 0, write_enable = 0, wb_drop = 0, dec_stall = 0 with dec_rs1_en = 1.
- **Priority**: wb_valid = 1 (x5, 0x11) and md_valid = 1 (x6, 0x22) for 1 cycle -> write x5 = 0x11, md_ready = 0. Next cycle with wb_valid = 0 -> write x6 = 0x22, md_ready = 1.
- **Starvation** (STARVE_LIMIT = 4): wb_valid held high, md_valid high from cycle 0 -> stall_pipe = 1 and md_ready = 1 in cycle 4, x6 written in cycle 4, wb_drop set (pipeline did not bubble).
- **RAW/WAW**
  - md_issue x7 -> dec_rs2 = 7 stalls from the next cycle.
  - dec_rd = 7 stalls.
  - On the acceptance cycle for x7, dec_stall = 0 and write_addr = 7.
- **Same-cycle set/clear**: accept x9 while md_issue x9 -> busy[9] = 1 afterwards.
- **x0 handling**
  - md_issue x0 -> busy stays 0.
  - Mul/div result to x0 -> md_ready = 1, write_enable = 0.
